// File: rtl/hash_pkg.sv
// Shared types and helpers for the parametrised byte-stream hash engine.
package hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_t;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MAX_W  = 128;

  // Number of byte copies needed to span a state word of the given width.
  function automatic int unsigned repl_count(input int unsigned width);
    return width / BYTE_W;
  endfunction

  // Left-rotate the low `width` bits of x by amt (modulo width); upper bits are zeroed.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int unsigned     width,
                                            input int unsigned     amt);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] xm;
    int unsigned      s;
    s    = amt % width;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    xm   = x & mask;
    if (s == 0) begin
      return xm;
    end
    return ((xm << s) | (xm >> (width - s))) & mask;
  endfunction

endpackage

// File: rtl/hash_round_unit.sv
// One hash round: mix the replicated (byte ^ round index) into the state, then rotate.
module hash_round_unit
  import hash_pkg::*;
#(
  parameter int unsigned DIGEST_W = 32,
  parameter int unsigned ROT      = 5
) (
  input  logic [DIGEST_W-1:0] h,
  input  logic [7:0]          b,
  input  logic [7:0]          r,
  output logic [DIGEST_W-1:0] h_next_c
);

  localparam int unsigned REPL = repl_count(DIGEST_W);

  logic [DIGEST_W-1:0] mixed;

  assign mixed    = h ^ {REPL{b ^ r}};
  assign h_next_c = DIGEST_W'(rotl(MAX_W'(mixed), DIGEST_W, ROT));

endmodule

// File: rtl/param_hash_engine.sv
// Iterative hash engine: absorbs one byte per ROUNDS+1 cycles, length-strengthened
// finalisation, held digest released by digest_ready, abort from any state.
module param_hash_engine
  import hash_pkg::*;
#(
  parameter int unsigned          DIGEST_W = 32,
  parameter int unsigned          ROUNDS   = 8,
  parameter int unsigned          ROT      = 5,
  parameter int unsigned          LEN_W    = 16,
  parameter logic [DIGEST_W-1:0]  IV       = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          in_byte,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic                busy
);

  localparam logic [7:0]       R_LAST  = 8'(ROUNDS - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t              state;
  logic [DIGEST_W-1:0] h;
  logic [LEN_W-1:0]    len;
  logic [7:0]          r;
  logic [7:0]          b_q;
  logic                last_q;
  logic [DIGEST_W-1:0] h_round_c;
  logic [DIGEST_W-1:0] h_final_c;

  hash_round_unit #(
    .DIGEST_W (DIGEST_W),
    .ROT      (ROT)
  ) u_round (
    .h        (h),
    .b        (b_q),
    .r        (r),
    .h_next_c (h_round_c)
  );

  assign h_final_c = h ^ DIGEST_W'(len);

  // Control FSM; in_ready/busy/digest_valid are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      h            <= IV;
      len          <= '0;
      r            <= '0;
      b_q          <= '0;
      last_q       <= 1'b0;
      in_ready     <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else if (abort) begin
      state        <= ST_IDLE;
      h            <= IV;
      len          <= '0;
      r            <= '0;
      in_ready     <= 1'b0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            h        <= IV;
            len      <= '0;
            state    <= ST_WAIT;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (in_valid) begin
            b_q      <= in_byte;
            last_q   <= in_last;
            r        <= '0;
            state    <= ST_ROUND;
            in_ready <= 1'b0;
            if (len != LEN_MAX) begin
              len <= len + LEN_W'(1);
            end
          end
        end
        ST_ROUND: begin
          h <= h_round_c;
          r <= r + 8'd1;
          if (r == R_LAST) begin
            if (last_q) begin
              state <= ST_FINAL;
            end else begin
              state    <= ST_WAIT;
              in_ready <= 1'b1;
            end
          end
        end
        ST_FINAL: begin
          h            <= h_final_c;
          digest       <= h_final_c;
          digest_valid <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          if (digest_ready) begin
            state        <= ST_IDLE;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          in_ready     <= 1'b0;
          digest_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
